sha256_multiblock_core: RTL and testbench

//  Parametrised SHA-256 engine: hashes a pre-padded message of NUM_BLOCKS 512-bit blocks and returns the 256-bit digest.

---
 rtl/sha256_pkg.sv | 48 ++++
 rtl/sha256_round.sv | 28 ++
 rtl/sha256_multiblock_core.sv | 157 +++++++++++++++
 tb/tb_sha256_multiblock_core.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// SHA-256 constants, FSM state type and the FIPS 180-4 bitwise helper functions
// shared by the core and its round datapath.
package sha256_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, ROUND, UPDATE, DONE} state_t;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  // Rotations written as concatenations so every width is explicit.
  function automatic logic [31:0] big_s0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] big_s1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] small_s0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] small_s1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One SHA-256 compression round plus the next rolling-schedule word; purely combinational.
// Working variables are indexed a=0 .. h=7, schedule window W[0] is the oldest word.
module sha256_round
  import sha256_pkg::*;
(
  input  logic [7:0][31:0]  st_i,
  input  logic [31:0]       k_i,
  input  logic [15:0][31:0] w_i,
  output logic [7:0][31:0]  st_o,
  output logic [31:0]       w_new_o
);
  logic [31:0] t1, t2;

  always_comb begin
    t1      = st_i[7] + big_s1(st_i[4]) + ch(st_i[4], st_i[5], st_i[6]) + k_i + w_i[0];
    t2      = big_s0(st_i[0]) + maj(st_i[0], st_i[1], st_i[2]);
    st_o[0] = t1 + t2;
    st_o[1] = st_i[0];
    st_o[2] = st_i[1];
    st_o[3] = st_i[2];
    st_o[4] = st_i[3] + t1;
    st_o[5] = st_i[4];
    st_o[6] = st_i[5];
    st_o[7] = st_i[6];
    w_new_o = small_s1(w_i[14]) + w_i[9] + small_s0(w_i[1]) + w_i[0];
  end

endmodule

// File: rtl/sha256_multiblock_core.sv
// Multi-block SHA-256 engine, one round per clock, valid/ready on input and output.
// Define SHA256_DOUBLE_HASH_EN to run an automatic second pass (digest = SHA256(SHA256(msg))).
module sha256_multiblock_core
  import sha256_pkg::*;
#(
  parameter int NUM_BLOCKS = 2,
  parameter int BLK_CNT_W  = $clog2(NUM_BLOCKS + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_BLOCKS*512-1:0] message,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [255:0]              digest,
  output logic                      busy
);
  state_t                    state_q, state_d;
  logic [NUM_BLOCKS*512-1:0] msg_q;
  logic [7:0][31:0]          h_q, st_q, st_next, h_sum;
  logic [15:0][31:0]         w_q, blk_w;
  logic [31:0]               w_new;
  logic [511:0]              blk_data;
  logic [BLK_CNT_W-1:0]      blk_q;
  logic [5:0]                t_q;
  logic                      out_valid_q;
  logic [255:0]              digest_q, h_flat;
  logic                      last_blk;
`ifdef SHA256_DOUBLE_HASH_EN
  logic                      pass_q;
`endif

  assign in_ready  = (state_q == IDLE) && !rst;
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign digest    = digest_q;
  assign last_blk  = (blk_q == BLK_CNT_W'(NUM_BLOCKS - 1));

  // Block 0 sits in the message MSBs, word 0 in the MSBs of each block.
  always_comb begin
    blk_data = msg_q[512*(NUM_BLOCKS-1-int'(blk_q)) +: 512];
    for (int j = 0; j < 16; j++) blk_w[j] = blk_data[511-32*j -: 32];
    for (int i = 0; i < 8; i++) begin
      h_sum[i]               = h_q[i] + st_q[i];
      h_flat[255-32*i -: 32] = h_q[i];
    end
  end

  sha256_round u_round (
    .st_i   (st_q),
    .k_i    (K[t_q]),
    .w_i    (w_q),
    .st_o   (st_next),
    .w_new_o(w_new)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (in_valid) state_d = LOAD;
      LOAD:   state_d = ROUND;
      ROUND:  if (t_q == 6'd63) state_d = UPDATE;
      UPDATE: begin
        if (!last_blk) state_d = LOAD;
`ifdef SHA256_DOUBLE_HASH_EN
        else if (!pass_q) state_d = LOAD;
`endif
        else state_d = DONE;
      end
      DONE:   if (out_valid_q && out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      blk_q       <= '0;
      t_q         <= '0;
      out_valid_q <= 1'b0;
      digest_q    <= '0;
`ifdef SHA256_DOUBLE_HASH_EN
      pass_q      <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (in_valid) begin
          blk_q <= '0;
`ifdef SHA256_DOUBLE_HASH_EN
          pass_q <= 1'b0;
`endif
        end
        LOAD:   t_q <= '0;
        ROUND:  t_q <= t_q + 6'd1;
        UPDATE: begin
          if (!last_blk) blk_q <= blk_q + BLK_CNT_W'(1);
`ifdef SHA256_DOUBLE_HASH_EN
          else pass_q <= 1'b1;
`endif
        end
        // Digest is captured once, then held until the consumer takes it.
        DONE: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            digest_q    <= h_flat;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    case (state_q)
      IDLE: if (in_valid) begin
        msg_q <= message;
        for (int i = 0; i < 8; i++) h_q[i] <= IV[i];
      end
      LOAD: begin
        st_q <= h_q;
`ifdef SHA256_DOUBLE_HASH_EN
        if (!pass_q) w_q <= blk_w;
`else
        w_q <= blk_w;
`endif
      end
      ROUND: begin
        st_q <= st_next;
        w_q  <= {w_new, w_q[15:1]};
      end
      UPDATE: begin
`ifdef SHA256_DOUBLE_HASH_EN
        // Second pass hashes the 256-bit first digest as one padded block.
        if (last_blk && !pass_q) begin
          for (int i = 0; i < 8; i++) begin
            h_q[i] <= IV[i];
            w_q[i] <= h_sum[i];
          end
          w_q[8] <= 32'h8000_0000;
          for (int i = 9; i < 15; i++) w_q[i] <= 32'h0;
          w_q[15] <= 32'h0000_0100;
        end else begin
          h_q <= h_sum;
        end
`else
        h_q <= h_sum;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sha256_multiblock_core.sv
// Self-checking bench: known vectors, random messages against a full-schedule SHA-256 model,
// backpressure, mid-hash reset and ignored input while busy.
module tb_sha256_multiblock_core;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         iv1, ir1, ov1, ordy1, busy1;
  logic [511:0] m1;
  logic [255:0] d1;
  logic          iv2, ir2, ov2, ordy2, busy2;
  logic [1023:0] m2;
  logic [255:0]  d2;

  sha256_multiblock_core #(.NUM_BLOCKS(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .message(m1),
    .out_valid(ov1), .out_ready(ordy1), .digest(d1), .busy(busy1));

  sha256_multiblock_core #(.NUM_BLOCKS(2)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .message(m2),
    .out_valid(ov2), .out_ready(ordy2), .digest(d2), .busy(busy2));

`ifdef SHA256_DOUBLE_HASH_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  localparam logic [31:0] KT [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [31:0] IVT [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook SHA-256 over nb blocks taken from the MSBs of m (full 64-word schedule).
  function automatic logic [255:0] sha_ref(input logic [1023:0] m, input int nb);
    logic [31:0]  H [8];
    logic [31:0]  v [8];
    logic [31:0]  W [64];
    logic [31:0]  t1, t2, e, a;
    logic [511:0] b;
    for (int i = 0; i < 8; i++) H[i] = IVT[i];
    for (int k = 0; k < nb; k++) begin
      b = m[1023-512*k -: 512];
      for (int j = 0; j < 16; j++) W[j] = b[511-32*j -: 32];
      for (int j = 16; j < 64; j++)
        W[j] = (rotr(W[j-2], 17) ^ rotr(W[j-2], 19) ^ (W[j-2] >> 10)) + W[j-7]
             + (rotr(W[j-15], 7) ^ rotr(W[j-15], 18) ^ (W[j-15] >> 3)) + W[j-16];
      for (int i = 0; i < 8; i++) v[i] = H[i];
      for (int j = 0; j < 64; j++) begin
        e  = v[4];
        a  = v[0];
        t1 = v[7] + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & v[5]) ^ (~e & v[6])) + KT[j] + W[j];
        t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & v[1]) ^ (a & v[2]) ^ (v[1] & v[2]));
        for (int i = 7; i > 0; i--) v[i] = v[i-1];
        v[4] = v[4] + t1;
        v[0] = t1 + t2;
      end
      for (int i = 0; i < 8; i++) H[i] = H[i] + v[i];
    end
    return {H[0], H[1], H[2], H[3], H[4], H[5], H[6], H[7]};
  endfunction

  function automatic logic [255:0] hash_ref(input logic [1023:0] m, input int nb);
    logic [255:0] d;
    d = sha_ref(m, nb);
    if (EXTRA == 1) d = sha_ref({d, 32'h8000_0000, 192'h0, 32'h100, 512'h0}, 1);
    return d;
  endfunction

  function automatic logic [1023:0] rand_msg();
    logic [1023:0] r;
    for (int i = 0; i < 32; i++) r[1023-32*i -: 32] = $urandom;
    return r;
  endfunction

  function automatic int exp_lat(input int nb);
    return 66 * (nb + EXTRA) + 1;
  endfunction

  // Present a message and return at the falling edge right after the accept edge.
  task automatic start(input int nb, input logic [1023:0] m);
    int n = 0;
    @(negedge clk);
    while (!(nb == 1 ? ir1 : ir2) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_before_accept", (nb == 1 ? ir1 : ir2), 1'b1);
    if (nb == 1) begin iv1 = 1'b1; m1 = m[1023:512]; end
    else begin iv2 = 1'b1; m2 = m; end
    @(negedge clk);
    iv1 = 1'b0;
    iv2 = 1'b0;
  endtask

  // Count rising edges since the accept edge until out_valid shows up.
  task automatic wait_out(input int nb, input int already, output int lat);
    lat = already;
    while (!(nb == 1 ? ov1 : ov2) && lat < 1000) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic take(input int nb);
    if (nb == 1) ordy1 = 1'b1; else ordy2 = 1'b1;
    @(negedge clk);
    ordy1 = 1'b0;
    ordy2 = 1'b0;
    chk("out_valid_drops_on_handshake", (nb == 1 ? ov1 : ov2), 1'b0);
    chk("idle_after_handshake", (nb == 1 ? busy1 : busy2), 1'b0);
  endtask

  task automatic run(input string name, input int nb, input logic [1023:0] m, input logic [255:0] exp);
    int lat;
    start(nb, m);
    wait_out(nb, 0, lat);
    chk({name, "_latency"}, lat, exp_lat(nb));
    chk({name, "_digest"}, (nb == 1 ? d1 : d2), exp);
    take(nb);
  endtask

  typedef struct {
    string         name;
    int            nb;
    logic [1023:0] msg;
    logic [255:0]  exp;
  } vec_t;

  initial begin
    vec_t          tbl [$];
    logic [511:0]  abc_blk;
    logic [447:0]  str2;
    logic [1023:0] abc_msg, two_msg, ma, junk;
    logic [255:0]  abc_exp, two_exp, cap;
    int            lat;

    rst = 1'b1; iv1 = 1'b0; iv2 = 1'b0; ordy1 = 1'b0; ordy2 = 1'b0; m1 = '0; m2 = '0;

    abc_blk = {32'h61626380, 448'h0, 32'h18};
    abc_msg = {abc_blk, 512'h0};
    str2    = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
    two_msg = {str2, 32'h8000_0000, 32'h0, 448'h0, 64'h1c0};
`ifdef SHA256_DOUBLE_HASH_EN
    abc_exp = 256'h4f8b42c22dd3729b519ba6f68d2da7cc5b2d606d05daed5ad5128cc03e6c6358;
    two_exp = hash_ref(two_msg, 2);
`else
    abc_exp = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    two_exp = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
`endif
    tbl.push_back('{"abc", 1, abc_msg, abc_exp});
    tbl.push_back('{"two_block", 2, two_msg, two_exp});
    for (int i = 0; i < 3; i++) begin
      ma = rand_msg();
      tbl.push_back('{$sformatf("rand1_%0d", i), 1, ma, hash_ref(ma, 1)});
    end
    for (int i = 0; i < 2; i++) begin
      ma = rand_msg();
      tbl.push_back('{$sformatf("rand2_%0d", i), 2, ma, hash_ref(ma, 2)});
    end

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready1", ir1, 1'b0);
    chk("rst_in_ready2", ir2, 1'b0);
    chk("rst_out_valid1", ov1, 1'b0);
    chk("rst_out_valid2", ov2, 1'b0);
    chk("rst_busy1", busy1, 1'b0);
    chk("rst_busy2", busy2, 1'b0);
    chk("rst_digest1", d1, 256'h0);
    chk("rst_digest2", d2, 256'h0);
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", ir1, 1'b1);

    for (int i = 0; i < tbl.size(); i++) run(tbl[i].name, tbl[i].nb, tbl[i].msg, tbl[i].exp);

    // Backpressure: digest and out_valid hold while out_ready stays low.
    start(1, abc_msg);
    wait_out(1, 0, lat);
    chk("bp_latency", lat, exp_lat(1));
    cap = d1;
    chk("bp_digest", cap, abc_exp);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_out_valid_held", ov1, 1'b1);
      chk("bp_digest_stable", d1, cap);
      chk("bp_in_ready_low", ir1, 1'b0);
    end
    take(1);
    run("abc_after_bp", 1, abc_msg, abc_exp);

    // Reset while round t=30 is pending.
    start(1, abc_msg);
    repeat (31) @(negedge clk);
    chk("busy_before_abort", busy1, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_out_valid", ov1, 1'b0);
    chk("abort_busy", busy1, 1'b0);
    chk("abort_in_ready_low", ir1, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (ov1 !== 1'b0) begin
        chk("abort_no_stale_output", ov1, 1'b0);
        break;
      end
    end
    chk("abort_idle_digest_cleared", d1, 256'h0);
    run("abc_after_abort", 1, abc_msg, abc_exp);

    // Input traffic while busy must be ignored.
    ma = rand_msg();
    start(2, ma);
    for (int i = 0; i < 40; i++) begin
      junk = rand_msg();
      iv2 = 1'($urandom_range(0, 1));
      m2 = junk;
      chk("busy_in_ready_low", ir2, 1'b0);
      @(posedge clk);
      @(negedge clk);
    end
    iv2 = 1'b0;
    wait_out(2, 40, lat);
    chk("busy_ignore_latency", lat, exp_lat(2));
    chk("busy_ignore_digest", d2, hash_ref(ma, 2));
    take(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
